// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, ALU op codes, FSM state
// type and the request payload carried from a requester to the ALU.
package alu_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CTRL_W = 3;

    // ALU op codes; the arbiter passes these through without decoding them.
    localparam logic [CTRL_W-1:0] ALU_AND  = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_ADDI = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_MUL  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_SRAI = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 3'b101;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0]  data1;
        logic [WIDTH-1:0]  data2;
        logic [CTRL_W-1:0] ctrl;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of all handshake and datapath signals around the ALU arbiter.
//   slave  : view of the arbiter itself
//   master : view of the surrounding environment (requesters, ALU, consumer)
interface alu_arbiter_if;
    import alu_pkg::*;

    // requester 0
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [WIDTH-1:0]  req0_data1_i;
    logic [WIDTH-1:0]  req0_data2_i;
    logic [CTRL_W-1:0] req0_ctrl_i;
    // requester 1
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [WIDTH-1:0]  req1_data1_i;
    logic [WIDTH-1:0]  req1_data2_i;
    logic [CTRL_W-1:0] req1_ctrl_i;
    // combinational ALU
    logic [WIDTH-1:0]  alu_data1_o;
    logic [WIDTH-1:0]  alu_data2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [WIDTH-1:0]  alu_data_i;
    logic              alu_zero_i;
    // response channel
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_id_o;
    logic [WIDTH-1:0]  rsp_data_o;
    logic              rsp_zero_o;

    modport slave (
        input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        input  alu_data_i, alu_zero_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o
    );

    modport master (
        output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        output alu_data_i, alu_zero_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a "last granted" pointer.
//   clk, rst      : clock, async active-high reset (last resets to 1)
//   valid[1:0]    : request valids
//   update        : a grant was accepted this cycle
//   update_id     : index of the accepted requester
//   grant_valid_c : some requester is valid
//   grant_id_c    : granted requester (~last preferred)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       update,
    input  logic       update_id,
    output logic       grant_valid_c,
    output logic       grant_id_c
);

    logic last;

    // Reset value 1 makes requester 0 the first preferred one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= update_id;
        end
    end

    // Prefer ~last; fall back to last only when the preferred one is idle.
    always_comb begin
        grant_valid_c = valid[0] | valid[1];
        grant_id_c    = last;
        if (valid[~last]) begin
            grant_id_c = ~last;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters. A request
// is accepted in IDLE, its operands drive the ALU for one EXEC cycle, and the
// registered result is returned tagged with the requester index in RESP.
//   clk_i, rst_i : clock, async active-high reset
//   bus          : requester, ALU and response signals (slave view)
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    alu_arbiter_if.slave bus
);

    state_e            state;
    state_e            state_nxt;
    logic              grant_valid_c;
    logic              grant_id_c;
    logic              accept_c;
    logic              ready0_c;
    logic              ready1_c;
    alu_req_t          req_sel;
    alu_req_t          alu_req;
    logic              rsp_valid;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_zero;

    rr_arb2 u_arb (
        .clk           (clk_i),
        .rst           (rst_i),
        .valid         ({bus.req1_valid_i, bus.req0_valid_i}),
        .update        (accept_c),
        .update_id     (grant_id_c),
        .grant_valid_c (grant_valid_c),
        .grant_id_c    (grant_id_c)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept_c)        state_nxt = ST_EXEC;
            ST_EXEC:                      state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready_i) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs; ready is forced low while reset is asserted.
    always_comb begin
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        if (state == ST_IDLE && !rst_i && grant_valid_c) begin
            ready0_c = ~grant_id_c;
            ready1_c = grant_id_c;
        end
        accept_c = (ready0_c & bus.req0_valid_i) | (ready1_c & bus.req1_valid_i);
    end

    // Payload of the granted requester.
    always_comb begin
        if (grant_id_c) begin
            req_sel = '{data1: bus.req1_data1_i, data2: bus.req1_data2_i, ctrl: bus.req1_ctrl_i};
        end else begin
            req_sel = '{data1: bus.req0_data1_i, data2: bus.req0_data2_i, ctrl: bus.req0_ctrl_i};
        end
    end

    // Operand and response registers; ALU operands persist between ops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_req   <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                alu_req <= req_sel;
                rsp_id  <= grant_id_c;
            end
            if (state == ST_EXEC) begin
                rsp_data <= bus.alu_data_i;
                rsp_zero <= bus.alu_zero_i;
            end
            rsp_valid <= (state_nxt == ST_RESP);
        end
    end

    assign bus.req0_ready_o = ready0_c;
    assign bus.req1_ready_o = ready1_c;
    assign bus.alu_data1_o  = alu_req.data1;
    assign bus.alu_data2_o  = alu_req.data2;
    assign bus.alu_ctrl_o   = alu_req.ctrl;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_id_o     = rsp_id;
    assign bus.rsp_data_o   = rsp_data;
    assign bus.rsp_zero_o   = rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// fairness / backpressure / reset sequences and randomized transactions
// checked against a transaction-level model of the round-robin rule.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic m_last = 1'b1;   // model of the round-robin pointer

    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND:  return a & b;
            ALU_ADD:  return a + b;
            ALU_ADDI: return a + b;
            ALU_MUL:  return 32'(a * b);
            ALU_SRAI: return 32'($signed(a) >>> b[4:0]);
            ALU_SLL:  return a << b[4:0];
            ALU_XOR:  return a ^ b;
            default:  return a - b;
        endcase
    endfunction

    // Environment ALU driven by the arbiter's registered operands.
    always_comb begin
        bus.alu_data_i = ref_alu(bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o);
        bus.alu_zero_i = (ref_alu(bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o) == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction starting in IDLE: offer requests, check the grant,
    // EXEC operands, response contents and holding under backpressure.
    task automatic run_txn(input string tag,
                           input logic v0, input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic v1, input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                           input int bp, input logic keep,
                           input logic exp_id, input logic [31:0] exp_data, input logic exp_zero);
        logic [2:0]  ec;
        logic [31:0] ea;
        ec = exp_id ? c1 : c0;
        ea = exp_id ? a1 : a0;
        bus.req0_valid_i = v0; bus.req0_ctrl_i = c0; bus.req0_data1_i = a0; bus.req0_data2_i = b0;
        bus.req1_valid_i = v1; bus.req1_ctrl_i = c1; bus.req1_data1_i = a1; bus.req1_data2_i = b1;
        @(negedge clk);
        chk({tag, " ready0"}, 32'(bus.req0_ready_o), 32'(exp_id == 1'b0));
        chk({tag, " ready1"}, 32'(bus.req1_ready_o), 32'(exp_id == 1'b1));
        @(posedge clk); #1;
        if (!keep) begin
            bus.req0_valid_i = 1'b0;
            bus.req1_valid_i = 1'b0;
        end
        @(negedge clk);
        chk({tag, " exec rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, " exec alu_ctrl"}, 32'(bus.alu_ctrl_o), 32'(ec));
        chk({tag, " exec alu_data1"}, bus.alu_data1_o, ea);
        chk({tag, " exec readies"}, 32'(bus.req0_ready_o | bus.req1_ready_o), 32'd0);
        @(posedge clk); #1;
        bus.rsp_ready_i = (bp == 0);
        @(negedge clk);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        chk({tag, " rsp_data"}, bus.rsp_data_o, exp_data);
        chk({tag, " rsp_zero"}, 32'(bus.rsp_zero_o), 32'(exp_zero));
        chk({tag, " rsp_id"}, 32'(bus.rsp_id_o), 32'(exp_id));
        chk({tag, " resp readies"}, 32'(bus.req0_ready_o | bus.req1_ready_o), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            if (i == bp - 1) bus.rsp_ready_i = 1'b1;
            @(negedge clk);
            chk({tag, " hold rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
            chk({tag, " hold rsp_data"}, bus.rsp_data_o, exp_data);
            chk({tag, " hold rsp_id"}, 32'(bus.rsp_id_o), 32'(exp_id));
            chk({tag, " hold readies"}, 32'(bus.req0_ready_o | bus.req1_ready_o), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        m_last = exp_id;
    endtask

    // Reset-state check of every output.
    task automatic chk_reset_outputs(input string tag);
        chk({tag, " alu_data1"}, bus.alu_data1_o, 32'd0);
        chk({tag, " alu_data2"}, bus.alu_data2_o, 32'd0);
        chk({tag, " alu_ctrl"}, 32'(bus.alu_ctrl_o), 32'd0);
        chk({tag, " rsp_data"}, bus.rsp_data_o, 32'd0);
        chk({tag, " rsp_zero"}, 32'(bus.rsp_zero_o), 32'd0);
        chk({tag, " rsp_id"}, 32'(bus.rsp_id_o), 32'd0);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, " ready0"}, 32'(bus.req0_ready_o), 32'd0);
        chk({tag, " ready1"}, 32'(bus.req1_ready_o), 32'd0);
    endtask

    typedef struct {
        logic        v0;
        logic [2:0]  c0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        v1;
        logic [2:0]  c1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        exp_id;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        v0, v1, w, ez;
        logic [2:0]  c0, c1;
        logic [31:0] a0, b0, a1, b1, ed;

        vecs[0] = '{1'b1, ALU_ADD,  32'd5,        32'd7,        1'b0, ALU_AND, 32'd0, 32'd0, 1'b0, 32'd12,       1'b0};
        vecs[1] = '{1'b0, ALU_AND,  32'd0,        32'd0,        1'b1, ALU_SUB, 32'd9, 32'd9, 1'b1, 32'd0,        1'b1};
        vecs[2] = '{1'b1, ALU_AND,  32'hff00ff00, 32'h0f0f0f0f, 1'b0, ALU_AND, 32'd0, 32'd0, 1'b0, 32'h0f000f00, 1'b0};
        vecs[3] = '{1'b0, ALU_AND,  32'd0,        32'd0,        1'b1, ALU_XOR, 32'ha5a5a5a5, 32'ha5a5a5a5, 1'b1, 32'd0, 1'b1};
        vecs[4] = '{1'b1, ALU_SRAI, 32'h80000000, 32'd4,        1'b0, ALU_AND, 32'd0, 32'd0, 1'b0, 32'hf8000000, 1'b0};
        vecs[5] = '{1'b0, ALU_AND,  32'd0,        32'd0,        1'b1, ALU_ADDI, 32'hffffffff, 32'd1, 1'b1, 32'd0, 1'b1};
        vecs[6] = '{1'b1, ALU_MUL,  32'h00010000, 32'h00010000, 1'b0, ALU_AND, 32'd0, 32'd0, 1'b0, 32'd0,        1'b1};
        vecs[7] = '{1'b0, ALU_AND,  32'd0,        32'd0,        1'b1, ALU_SLL, 32'd3, 32'd4, 1'b1, 32'h30,       1'b0};

        bus.req0_valid_i = 1'b1; bus.req0_ctrl_i = ALU_ADD; bus.req0_data1_i = 32'd1; bus.req0_data2_i = 32'd2;
        bus.req1_valid_i = 1'b1; bus.req1_ctrl_i = ALU_ADD; bus.req1_data1_i = 32'd3; bus.req1_data2_i = 32'd4;
        bus.rsp_ready_i  = 1'b0;

        // Reset state, with both requesters valid to show readies stay low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(posedge clk); #1;

        // Directed vector table, single requester per vector.
        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i),
                    vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0,
                    vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1,
                    i % 3, 1'b0, vecs[i].exp_id, vecs[i].exp_data, vecs[i].exp_zero);
        end

        // Fairness: both valid continuously, four MUL 3x4.
        for (int i = 0; i < 4; i++) begin
            w = ~m_last;
            run_txn($sformatf("fair%0d", i),
                    1'b1, ALU_MUL, 32'd3, 32'd4, 1'b1, ALU_MUL, 32'd3, 32'd4,
                    0, 1'b1, w, 32'd12, 1'b0);
            chk($sformatf("fair%0d order", i), 32'(m_last), 32'(i % 2));
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(posedge clk); #1;

        // Backpressure: req0 wins, 5 stalled RESP cycles, pending req1 after.
        run_txn("bp_req0", 1'b1, ALU_ADD, 32'd10, 32'd20, 1'b1, ALU_XOR, 32'hf0f0f0f0, 32'h0ff00ff0,
                5, 1'b1, ~m_last, 32'd30, 1'b0);
        run_txn("bp_req1", 1'b0, ALU_ADD, 32'd10, 32'd20, 1'b1, ALU_XOR, 32'hf0f0f0f0, 32'h0ff00ff0,
                0, 1'b0, 1'b1, 32'hff00ff00, 1'b0);

        // Reset during EXEC of req1 SLL 1,31.
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b1; bus.req1_ctrl_i = ALU_SLL; bus.req1_data1_i = 32'd1; bus.req1_data2_i = 32'd31;
        @(negedge clk);
        chk("rst_mid accept", 32'(bus.req1_ready_o), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid no rsp %0d", i), 32'(bus.rsp_valid_o), 32'd0);
            @(posedge clk); #1;
        end
        run_txn("rst_retry", 1'b1, ALU_SLL, 32'd1, 32'd31, 1'b1, ALU_SLL, 32'd1, 32'd31,
                1, 1'b0, 1'b0, 32'h80000000, 1'b0);

        // Randomized transactions against the round-robin model.
        for (int i = 0; i < 40; i++) begin
            {v1, v0} = 2'($urandom_range(1, 3));
            c0 = 3'($urandom_range(0, 7)); a0 = $urandom; b0 = $urandom;
            c1 = 3'($urandom_range(0, 7)); a1 = $urandom; b1 = $urandom;
            if ($urandom_range(0, 3) == 0) begin b0 = a0; b1 = a1; end
            if (v0 && v1) w = ~m_last;
            else          w = v1;
            ed = w ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
            ez = (ed == 32'd0);
            run_txn($sformatf("rnd%0d", i), v0, c0, a0, b0, v1, c1, a1, b1,
                    $urandom_range(0, 3), 1'b0, w, ed, ez);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
